bus_protocol_checker: RTL and testbench
=======================================

BUS_PROTOCOL_CHECKER -- requirements
Module: bus_protocol_checker

Interface
REQ-001 Parameter NUM_CH, default 4: number of monitored bus channels, 1..16.
REQ-002 Parameter ADDR_W, default 32: address width per channel.
REQ-003 Parameter TIMEOUT_CYCLES, default 255: maximum request-to-grant wait, 1..65535.
REQ-004 Parameter CNT_W, default 16: error counter width.
REQ-005 Port clk_i, input, 1: single clock; all logic rising-edge.
REQ-006 Port reset_i, input, 1: synchronous active-high reset.
REQ-007 Port ch_read_i, input, NUM_CH: per-channel read request.
REQ-008 Port ch_write_i, input, NUM_CH: per-channel write request.
REQ-009 Port ch_grant_i, input, NUM_CH: per-channel grant.
REQ-010 Port ch_addr_i, input, NUM_CH*ADDR_W: per-channel address; channel n at bits [n*ADDR_W +: ADDR_W].
REQ-011 Port clear_i, input, 1: clears sticky status and counter.
REQ-012 Port irq_en_i, input, 1: interrupt enable.
REQ-013 Port err_valid_o, output, 1: one-cycle error report strobe.
REQ-014 Port err_code_o, output, 3: code of reported error.
REQ-015 Port err_ch_o, output, 4: channel of reported error.
REQ-016 Port err_status_o, output, NUM_CH: sticky per-channel error flags.
REQ-017 Port err_count_o, output, CNT_W: saturating count of error cycles.
REQ-018 Port irq_o, output, 1: interrupt, registered.

Function
REQ-019 Each channel SHALL run an independent FSM: IDLE, WAIT_RD, WAIT_WR.
REQ-020 IDLE: read without grant -> WAIT_RD; write without grant -> WAIT_WR; capture address and clear wait counter on entry.
REQ-021 WAIT_x: grant with same-direction request -> IDLE; any error below -> IDLE, except TIMEOUT, which stays in WAIT_x.
REQ-022 Request with grant in same cycle SHALL complete with no state change.
REQ-023 Codes: 1 RW_CONFLICT (read&write), 2 UNEXPECTED_GRANT (grant, no request), 3 ADDR_UNSTABLE (address differs from captured in WAIT_x), 4 DIR_CHANGE (opposite direction in WAIT_x), 5 REQ_DROPPED (no request in WAIT_x), 6 TIMEOUT; 0 none.
REQ-024 Several errors on one channel in one cycle: lowest code reported.
REQ-025 Errors on several channels in one cycle: err_ch_o = lowest channel index; err_status_o sets every erring channel.
REQ-026 err_valid_o, err_code_o, err_ch_o SHALL be registered, one cycle after the violating cycle; code/ch hold 0 when err_valid_o low.
REQ-027 err_count_o increments by one per cycle with any error, saturates at all-ones.
REQ-028 clear_i zeroes err_status_o and err_count_o next cycle; simultaneous new error SHALL win: flag set, count = 1.
REQ-029 irq_o = registered (|err_status_o) & irq_en_i.
REQ-030 Checker SHALL never drive bus signals; monitor only.

Reset
REQ-031 reset_i SHALL force all FSMs to IDLE, wait counters and captured addresses to 0.
REQ-032 During and after reset all outputs SHALL be 0.
REQ-033 Reset mid-request SHALL discard pending state; no error reported for the aborted request.

Configuration
REQ-034 Macro BPC_TIMEOUT_EN defined: per-channel wait counter (16 bits) increments each WAIT_x cycle; count reaching TIMEOUT_CYCLES raises TIMEOUT once per request.
REQ-035 Macro BPC_TIMEOUT_EN undefined: no counters synthesised; code 6 never produced; all other behaviour unchanged.

Verification
REQ-036 Ch0 read, addr 0x100, grant on 3rd cycle, addr stable -> no err_valid_o, count 0.
REQ-037 Ch1 write addr 0x200, addr changes to 0x204 next cycle before grant -> err_valid_o=1, code 3, ch 1, err_status_o[1]=1, one cycle later.
REQ-038 Ch2 and ch3 grant with no request same cycle -> code 2, ch 2, err_status_o=4'b1100, count 1.
REQ-039 BPC_TIMEOUT_EN, TIMEOUT_CYCLES=4, ch0 read never granted -> single code 6 report; later grant -> IDLE, no further error.
REQ-040 Ch0 read&write same cycle with clear_i=1 -> code 1, err_status_o[0]=1, count=1; irq_o=1 next cycle if irq_en_i=1.
REQ-041 reset_i asserted while ch1 in WAIT_WR -> outputs 0, FSM IDLE, no report after reset release.

Source files
------------

// File: rtl/bus_protocol_checker.sv
// bus_protocol_checker: passive monitor for NUM_CH request/grant bus channels.
// Each channel tracks its outstanding request and flags protocol violations.
// A registered error report, sticky status, a saturating error counter and
// an interrupt are produced.
// Optional feature: define BPC_TIMEOUT_EN to add per-channel 16-bit wait
// counters that raise TIMEOUT (code 6) once per request.
module bus_protocol_checker #(
  parameter int NUM_CH         = 4,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [NUM_CH-1:0]        ch_read_i,
  input  logic [NUM_CH-1:0]        ch_write_i,
  input  logic [NUM_CH-1:0]        ch_grant_i,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr_i,
  input  logic                     clear_i,
  input  logic                     irq_en_i,
  output logic                     err_valid_o,
  output logic [2:0]               err_code_o,
  output logic [3:0]               err_ch_o,
  output logic [NUM_CH-1:0]        err_status_o,
  output logic [CNT_W-1:0]         err_count_o,
  output logic                     irq_o
);

  localparam logic [2:0] CODE_NONE        = 3'd0;
  localparam logic [2:0] CODE_RW_CONFLICT = 3'd1;
  localparam logic [2:0] CODE_UNEXP_GRANT = 3'd2;
  localparam logic [2:0] CODE_ADDR_UNSTAB = 3'd3;
  localparam logic [2:0] CODE_DIR_CHANGE  = 3'd4;
  localparam logic [2:0] CODE_REQ_DROPPED = 3'd5;
  localparam logic [2:0] CODE_TIMEOUT     = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_RD,
    ST_WAIT_WR
  } ch_state_t;

  logic [NUM_CH-1:0]   err_vec;
  logic [3*NUM_CH-1:0] code_vec;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_state_t         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, addr_cur;
    logic              rd, wr, gnt, in_wait, done;
    logic              e_conf, e_ugnt, e_addr, e_dir, e_drop, e_tmo;
    logic [2:0]        code;

    assign rd       = ch_read_i[i];
    assign wr       = ch_write_i[i];
    assign gnt      = ch_grant_i[i];
    assign addr_cur = ch_addr_i[i*ADDR_W +: ADDR_W];
    assign in_wait  = (state_q != ST_IDLE);

    assign done   = ((state_q == ST_WAIT_RD) && rd && gnt) ||
                    ((state_q == ST_WAIT_WR) && wr && gnt);
    assign e_conf = rd && wr;
    assign e_ugnt = gnt && !rd && !wr;
    assign e_addr = in_wait && (addr_cur != addr_q);
    assign e_dir  = ((state_q == ST_WAIT_RD) && wr) ||
                    ((state_q == ST_WAIT_WR) && rd);
    assign e_drop = in_wait && !rd && !wr;

`ifdef BPC_TIMEOUT_EN
    logic [15:0] wait_q, wait_d;

    // Fires only on the cycle the count reaches its limit, so one report per request
    assign e_tmo = in_wait && !done && (wait_q == 16'(TIMEOUT_CYCLES - 1));

    // Wait counter held at zero while idle so it starts from zero on entry, saturating at the limit
    always_comb begin
      wait_d = wait_q;
      if (state_q == ST_IDLE) begin
        wait_d = '0;
      end else if (wait_q < 16'(TIMEOUT_CYCLES)) begin
        wait_d = wait_q + 16'd1;
      end
    end

    // Wait counter register
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        wait_q <= '0;
      end else begin
        wait_q <= wait_d;
      end
    end
`else
    assign e_tmo = 1'b0;
`endif

    // Lowest violated code wins, then next state and address capture
    always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      code    = CODE_NONE;
      if (e_conf) begin
        code = CODE_RW_CONFLICT;
      end else if (e_ugnt) begin
        code = CODE_UNEXP_GRANT;
      end else if (e_addr) begin
        code = CODE_ADDR_UNSTAB;
      end else if (e_dir) begin
        code = CODE_DIR_CHANGE;
      end else if (e_drop) begin
        code = CODE_REQ_DROPPED;
      end else if (e_tmo) begin
        code = CODE_TIMEOUT;
      end
      case (state_q)
        ST_IDLE: begin
          if (!e_conf && !gnt) begin
            if (rd) begin
              state_d = ST_WAIT_RD;
              addr_d  = addr_cur;
            end else if (wr) begin
              state_d = ST_WAIT_WR;
              addr_d  = addr_cur;
            end
          end
        end
        ST_WAIT_RD, ST_WAIT_WR: begin
          if (done || ((code != CODE_NONE) && (code != CODE_TIMEOUT))) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Channel state and captured address registers
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        state_q <= ST_IDLE;
        addr_q  <= '0;
      end else begin
        state_q <= state_d;
        addr_q  <= addr_d;
      end
    end

    assign err_vec[i]          = (code != CODE_NONE);
    assign code_vec[3*i +: 3]  = code;
  end

  logic       err_any;
  logic [2:0] sel_code;
  logic [3:0] sel_ch;

  assign err_any = |err_vec;

  // Pick the lowest-index erring channel for the report
  always_comb begin
    sel_code = CODE_NONE;
    sel_ch   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (err_vec[i]) begin
        sel_code = code_vec[3*i +: 3];
        sel_ch   = 4'(i);
      end
    end
  end

  // Registered report, sticky status, saturating counter and interrupt; new errors beat clear
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      err_valid_o  <= 1'b0;
      err_code_o   <= '0;
      err_ch_o     <= '0;
      err_status_o <= '0;
      err_count_o  <= '0;
      irq_o        <= 1'b0;
    end else begin
      err_valid_o <= err_any;
      err_code_o  <= sel_code;
      err_ch_o    <= sel_ch;
      irq_o       <= (|err_status_o) && irq_en_i;
      if (clear_i) begin
        err_status_o <= err_vec;
        err_count_o  <= err_any ? CNT_W'(1) : '0;
      end else begin
        err_status_o <= err_status_o | err_vec;
        if (err_any && (err_count_o != {CNT_W{1'b1}})) begin
          err_count_o <= err_count_o + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_protocol_checker.sv
// tb_bus_protocol_checker: scoreboard bench for bus_protocol_checker.
// Each stimulus cycle pushes the expected report; it is popped and compared
// after the following clock edge. Built with or without BPC_TIMEOUT_EN.
module tb_bus_protocol_checker;

  localparam int NUM_CH         = 4;
  localparam int ADDR_W         = 32;
  localparam int TIMEOUT_CYCLES = 4;
  localparam int CNT_W          = 4;

  logic                     clk;
  logic                     reset;
  logic [NUM_CH-1:0]        ch_read;
  logic [NUM_CH-1:0]        ch_write;
  logic [NUM_CH-1:0]        ch_grant;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic                     clear;
  logic                     irq_en;
  logic                     err_valid;
  logic [2:0]               err_code;
  logic [3:0]               err_ch;
  logic [NUM_CH-1:0]        err_status;
  logic [CNT_W-1:0]         err_count;
  logic                     irq;

  typedef struct {
    string      tag;
    logic       valid;
    logic [2:0] code;
    logic [3:0] ch;
    logic [3:0] status;
    logic [3:0] count;
    logic       irq;
  } expect_t;

  expect_t    exp_q[$];
  logic [3:0] model_status;
  logic [3:0] model_count;
  int         check_count;
  int         error_count;

  bus_protocol_checker #(
    .NUM_CH(NUM_CH),
    .ADDR_W(ADDR_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk),
    .reset_i(reset),
    .ch_read_i(ch_read),
    .ch_write_i(ch_write),
    .ch_grant_i(ch_grant),
    .ch_addr_i(ch_addr),
    .clear_i(clear),
    .irq_en_i(irq_en),
    .err_valid_o(err_valid),
    .err_code_o(err_code),
    .err_ch_o(err_ch),
    .err_status_o(err_status),
    .err_count_o(err_count),
    .irq_o(irq)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [127:0] mkAddr(input logic [31:0] a0, input logic [31:0] a1,
                                           input logic [31:0] a2, input logic [31:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic compareReport();
    expect_t e;
    if (exp_q.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      checkOutput({e.tag, ".valid"},  32'(err_valid),  32'(e.valid));
      checkOutput({e.tag, ".code"},   32'(err_code),   32'(e.code));
      checkOutput({e.tag, ".ch"},     32'(err_ch),     32'(e.ch));
      checkOutput({e.tag, ".status"}, 32'(err_status), 32'(e.status));
      checkOutput({e.tag, ".count"},  32'(err_count),  32'(e.count));
      checkOutput({e.tag, ".irq"},    32'(irq),        32'(e.irq));
    end
  endtask

  // Drive one cycle, predict the report from the expected error mask, then compare
  task automatic applyStimulus(input string tag, input logic rst,
                               input logic [3:0] rd, input logic [3:0] wr,
                               input logic [3:0] gnt, input logic [127:0] addr,
                               input logic clr, input logic ien,
                               input logic [3:0] err_mask, input logic [2:0] code);
    expect_t e;
    reset    = rst;
    ch_read  = rd;
    ch_write = wr;
    ch_grant = gnt;
    ch_addr  = addr;
    clear    = clr;
    irq_en   = ien;
    e.tag    = tag;
    if (rst) begin
      model_status = '0;
      model_count  = '0;
      e.valid = 1'b0; e.code = '0; e.ch = '0; e.status = '0; e.count = '0; e.irq = 1'b0;
    end else begin
      e.valid = |err_mask;
      e.code  = (|err_mask) ? code : 3'd0;
      e.ch    = '0;
      for (int i = 3; i >= 0; i--) begin
        if (err_mask[i]) e.ch = 4'(i);
      end
      e.irq = (|model_status) && ien;
      if (clr) begin
        model_status = err_mask;
        model_count  = (|err_mask) ? 4'd1 : 4'd0;
      end else begin
        model_status = model_status | err_mask;
        if ((|err_mask) && (model_count != 4'hF)) model_count = model_count + 4'd1;
      end
      e.status = model_status;
      e.count  = model_count;
    end
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    compareReport();
  endtask

  initial begin
    logic [127:0] a;
    logic [3:0]   tmo_mask;
    logic [2:0]   tmo_code;
    check_count  = 0;
    error_count  = 0;
    model_status = '0;
    model_count  = '0;
    reset = 1'b1; ch_read = '0; ch_write = '0; ch_grant = '0;
    ch_addr = '0; clear = 1'b0; irq_en = 1'b0;

    applyStimulus("reset0", 1, 4'b0000, 4'b0000, 4'b0000, '0, 0, 0, 4'b0000, 3'd0);
    applyStimulus("reset1", 1, 4'b0000, 4'b0000, 4'b0000, '0, 0, 0, 4'b0000, 3'd0);

    // Clean read on ch0, granted on the third cycle
    a = mkAddr(32'h100, 32'h0, 32'h0, 32'h0);
    applyStimulus("rd_enter", 0, 4'b0001, 4'b0000, 4'b0000, a, 0, 1, 4'b0000, 3'd0);
    applyStimulus("rd_wait",  0, 4'b0001, 4'b0000, 4'b0000, a, 0, 1, 4'b0000, 3'd0);
    applyStimulus("rd_grant", 0, 4'b0001, 4'b0000, 4'b0001, a, 0, 1, 4'b0000, 3'd0);
    applyStimulus("rd_idle",  0, 4'b0000, 4'b0000, 4'b0000, a, 0, 1, 4'b0000, 3'd0);

    // Address changes while ch1 write is waiting
    a = mkAddr(32'h100, 32'h200, 32'h0, 32'h0);
    applyStimulus("wr_enter", 0, 4'b0000, 4'b0010, 4'b0000, a, 0, 1, 4'b0000, 3'd0);
    a = mkAddr(32'h100, 32'h204, 32'h0, 32'h0);
    applyStimulus("addr_chg", 0, 4'b0000, 4'b0010, 4'b0000, a, 0, 1, 4'b0010, 3'd3);
    applyStimulus("wr_idle",  0, 4'b0000, 4'b0000, 4'b0000, a, 0, 1, 4'b0000, 3'd0);

    // Clear, then unexpected grants on ch2 and ch3 together
    applyStimulus("clear",    0, 4'b0000, 4'b0000, 4'b0000, a, 1, 1, 4'b0000, 3'd0);
    applyStimulus("ugnt",     0, 4'b0000, 4'b0000, 4'b1100, a, 0, 1, 4'b1100, 3'd2);
    applyStimulus("ugnt_idle",0, 4'b0000, 4'b0000, 4'b0000, a, 0, 1, 4'b0000, 3'd0);

    // Read/write conflict coinciding with clear: the new error wins
    applyStimulus("rw_clr",   0, 4'b0001, 4'b0001, 4'b0000, a, 1, 1, 4'b0001, 3'd1);
    applyStimulus("rw_idle",  0, 4'b0000, 4'b0000, 4'b0000, a, 0, 1, 4'b0000, 3'd0);
    applyStimulus("irq_off",  0, 4'b0000, 4'b0000, 4'b0000, a, 0, 0, 4'b0000, 3'd0);

    // Same-channel priority: address change and direction change together
    a = mkAddr(32'h100, 32'h204, 32'h300, 32'h0);
    applyStimulus("ch2_enter",0, 4'b0100, 4'b0000, 4'b0000, a, 0, 1, 4'b0000, 3'd0);
    a = mkAddr(32'h100, 32'h204, 32'h304, 32'h0);
    applyStimulus("ch2_prio", 0, 4'b0000, 4'b0100, 4'b0000, a, 0, 1, 4'b0100, 3'd3);

    // Request dropped on ch3, direction change on ch0
    a = mkAddr(32'h100, 32'h204, 32'h304, 32'h400);
    applyStimulus("ch3_enter",0, 4'b0000, 4'b1000, 4'b0000, a, 0, 1, 4'b0000, 3'd0);
    applyStimulus("ch3_drop", 0, 4'b0000, 4'b0000, 4'b0000, a, 0, 1, 4'b1000, 3'd5);
    applyStimulus("ch0_enter",0, 4'b0001, 4'b0000, 4'b0000, a, 0, 1, 4'b0000, 3'd0);
    applyStimulus("ch0_dir",  0, 4'b0000, 4'b0001, 4'b0000, a, 0, 1, 4'b0001, 3'd4);

    // Two channels err at once: lowest channel reported with its own code
    applyStimulus("multi",    0, 4'b1000, 4'b1000, 4'b0010, a, 0, 1, 4'b1010, 3'd2);

    // Request granted in the same cycle never enters a wait state
    applyStimulus("same_gnt", 0, 4'b1000, 4'b0000, 4'b1000, a, 0, 1, 4'b0000, 3'd0);
    applyStimulus("same_idle",0, 4'b0000, 4'b0000, 4'b0000, a, 0, 1, 4'b0000, 3'd0);

    // Reset while ch1 waits on a write: nothing reported afterwards
    a = mkAddr(32'h100, 32'h200, 32'h304, 32'h400);
    applyStimulus("wr1_enter",0, 4'b0000, 4'b0010, 4'b0000, a, 0, 1, 4'b0000, 3'd0);
    applyStimulus("wr1_wait", 0, 4'b0000, 4'b0010, 4'b0000, a, 0, 1, 4'b0000, 3'd0);
    applyStimulus("rst_mid",  1, 4'b0000, 4'b0010, 4'b0000, a, 0, 1, 4'b0000, 3'd0);
    applyStimulus("post_rst0",0, 4'b0000, 4'b0000, 4'b0000, a, 0, 1, 4'b0000, 3'd0);
    applyStimulus("post_rst1",0, 4'b0000, 4'b0000, 4'b0000, a, 0, 1, 4'b0000, 3'd0);

    // Ch0 read left waiting: a single timeout when enabled, then a clean grant
`ifdef BPC_TIMEOUT_EN
    tmo_mask = 4'b0001;
    tmo_code = 3'd6;
`else
    tmo_mask = 4'b0000;
    tmo_code = 3'd0;
`endif
    a = mkAddr(32'h100, 32'h200, 32'h304, 32'h400);
    applyStimulus("tmo_enter",0, 4'b0001, 4'b0000, 4'b0000, a, 0, 0, 4'b0000, 3'd0);
    applyStimulus("tmo_w1",   0, 4'b0001, 4'b0000, 4'b0000, a, 0, 0, 4'b0000, 3'd0);
    applyStimulus("tmo_w2",   0, 4'b0001, 4'b0000, 4'b0000, a, 0, 0, 4'b0000, 3'd0);
    applyStimulus("tmo_w3",   0, 4'b0001, 4'b0000, 4'b0000, a, 0, 0, 4'b0000, 3'd0);
    applyStimulus("tmo_w4",   0, 4'b0001, 4'b0000, 4'b0000, a, 0, 0, tmo_mask, tmo_code);
    applyStimulus("tmo_w5",   0, 4'b0001, 4'b0000, 4'b0000, a, 0, 0, 4'b0000, 3'd0);
    applyStimulus("tmo_w6",   0, 4'b0001, 4'b0000, 4'b0000, a, 0, 0, 4'b0000, 3'd0);
    applyStimulus("tmo_gnt",  0, 4'b0001, 4'b0000, 4'b0001, a, 0, 0, 4'b0000, 3'd0);
    applyStimulus("tmo_idle", 0, 4'b0000, 4'b0000, 4'b0000, a, 0, 0, 4'b0000, 3'd0);

    // Error counter saturates at all-ones
    applyStimulus("sat_clear",0, 4'b0000, 4'b0000, 4'b0000, a, 1, 0, 4'b0000, 3'd0);
    for (int n = 0; n < 17; n++) begin
      applyStimulus($sformatf("sat_%0d", n), 0, 4'b0000, 4'b0000, 4'b0001, a, 0, 0,
                    4'b0001, 3'd2);
    end
    applyStimulus("sat_clr2", 0, 4'b0000, 4'b0000, 4'b0000, a, 1, 1, 4'b0000, 3'd0);
    applyStimulus("sat_idle", 0, 4'b0000, 4'b0000, 4'b0000, a, 0, 1, 4'b0000, 3'd0);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
